// File: rtl/conv_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_port_arbiter
// Purpose  : Burst arbiter sharing the convolution data memory among
//            write-back (id 0) and two line/filter readers (ids 1, 2).
// Revision : 1.0
// ============================================================================
module conv_mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*LEN_W-1:0]    req_len,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [2:0]            gnt,
    output logic [2:0]            beat_ack,
    output logic [2:0]            burst_done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rd_valid,
    output logic [1:0]            rd_id,
    output logic [DATA_W-1:0]     rd_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_id;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat;
    logic               r_rr;      // 0: prefer id 1, 1: prefer id 2

    logic [1:0]         w_win_id;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [LEN_W-1:0]   w_win_len;

    function automatic logic [2:0] onehot(input logic [1:0] id);
        case (id)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    always_comb begin
        w_win_id = 2'd0;
        if (req[0])
            w_win_id = 2'd0;
        else if (req[1] && (!req[2] || !r_rr))
            w_win_id = 2'd1;
        else if (req[2])
            w_win_id = 2'd2;

        w_win_addr = req_addr[ADDR_W-1:0];
        w_win_len  = req_len[LEN_W-1:0];
        case (w_win_id)
            2'd1: begin
                w_win_addr = req_addr[2*ADDR_W-1:ADDR_W];
                w_win_len  = req_len[2*LEN_W-1:LEN_W];
            end
            2'd2: begin
                w_win_addr = req_addr[3*ADDR_W-1:2*ADDR_W];
                w_win_len  = req_len[3*LEN_W-1:2*LEN_W];
            end
            default: ;
        endcase
    end

    assign mem_wdata = mem_we ? wr_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_id       <= 2'd0;
            r_len      <= '0;
            r_beat     <= '0;
            r_rr       <= 1'b0;
            gnt        <= 3'b000;
            beat_ack   <= 3'b000;
            burst_done <= 3'b000;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_id      <= 2'd0;
            rd_data    <= '0;
        end else begin
            // Read data is captured on the edge closing each read beat
            rd_valid <= mem_re;
            if (mem_re) begin
                rd_id   <= r_id;
                rd_data <= mem_rdata;
            end

            case (r_state)
                S_IDLE: begin
                    gnt        <= 3'b000;
                    burst_done <= 3'b000;
                    if (|req) begin
                        r_id   <= w_win_id;
                        r_len  <= w_win_len;
                        r_beat <= '0;
                        gnt    <= onehot(w_win_id);
                        if (w_win_id != 2'd0)
                            r_rr <= (w_win_id == 2'd1);
                        if (w_win_len == '0) begin
                            r_state    <= S_GAP;
                            burst_done <= onehot(w_win_id);
                        end else begin
                            r_state  <= S_BURST;
                            mem_addr <= w_win_addr;
                            beat_ack <= onehot(w_win_id);
                            mem_re   <= (w_win_id != 2'd0);
                            mem_we   <= (w_win_id == 2'd0);
                        end
                    end
                end
                S_BURST: begin
                    if (r_beat == r_len - LEN_W'(1)) begin
                        r_state    <= S_GAP;
                        beat_ack   <= 3'b000;
                        mem_re     <= 1'b0;
                        mem_we     <= 1'b0;
                        burst_done <= onehot(r_id);
                    end else begin
                        r_beat   <= r_beat + LEN_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                S_GAP: begin
                    r_state    <= S_IDLE;
                    gnt        <= 3'b000;
                    burst_done <= 3'b000;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mem_port_arbiter
// Purpose  : Directed self-checking bench for conv_mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_conv_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;

    logic                 clk;
    logic                 rst;
    logic [2:0]           req;
    logic [3*ADDR_W-1:0]  req_addr;
    logic [3*LEN_W-1:0]   req_len;
    logic [DATA_W-1:0]    wr_data;
    logic [2:0]           gnt;
    logic [2:0]           beat_ack;
    logic [2:0]           burst_done;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_re;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 rd_valid;
    logic [1:0]           rd_id;
    logic [DATA_W-1:0]    rd_data;

    int total = 0;
    int bad   = 0;

    conv_mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wr_data    (wr_data),
        .gnt        (gnt),
        .beat_ack   (beat_ack),
        .burst_done (burst_done),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is a fixed function of the address
    assign mem_rdata = mem_addr[7:0] ^ 8'h5A;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        req_addr[id*ADDR_W +: ADDR_W] = a;
        req_len[id*LEN_W +: LEN_W]    = l;
    endtask

    task automatic wait_gnt(output logic [2:0] g, output int n);
        n = 0;
        while (gnt == 3'b000 && n < 20) begin
            step();
            n++;
        end
        g = gnt;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (gnt != 3'b000 && n < 20) begin
            step();
            n++;
        end
        chk("gnt_release", 32'(n < 20), 32'd1);
    endtask

    logic [7:0]        wd [3];
    logic [2:0]        exp_g [5];
    logic [ADDR_W-1:0] ea;
    logic [2:0]        g;
    int                n;

    initial begin
        rst = 1'b1; req = 3'b000; req_addr = '0; req_len = '0; wr_data = '0;
        wd[0] = 8'hA1; wd[1] = 8'hB2; wd[2] = 8'hC3;
        exp_g[0] = 3'b001; exp_g[1] = 3'b100; exp_g[2] = 3'b010;
        exp_g[3] = 3'b001; exp_g[4] = 3'b100;
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_done", 32'(burst_done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst = 1'b0;
        step();

        // T1: single read on id1
        set_req(1, 16'h0010, 6'd4);
        req = 3'b010;
        for (int i = 0; i < 4; i++) begin
            step();
            req = 3'b000;
            chk("t1_gnt", 32'(gnt), 32'h2);
            chk("t1_beat_ack", 32'(beat_ack), 32'h2);
            chk("t1_mem_re", 32'(mem_re), 32'd1);
            chk("t1_addr", 32'(mem_addr), 32'h10 + 32'(i));
            chk("t1_rd_valid", 32'(rd_valid), 32'(i > 0));
            if (i > 0) chk("t1_rd_data", 32'(rd_data), 32'((8'h10 + 8'(i - 1)) ^ 8'h5A));
            chk("t1_no_done", 32'(burst_done), 32'd0);
        end
        step();
        chk("t1_done", 32'(burst_done), 32'h2);
        chk("t1_last_valid", 32'(rd_valid), 32'd1);
        chk("t1_last_data", 32'(rd_data), 32'h13 ^ 32'h5A);
        chk("t1_last_id", 32'(rd_id), 32'd1);
        chk("t1_gap_re", 32'(mem_re), 32'd0);
        step();
        chk("t1_idle_gnt", 32'(gnt), 32'd0);
        chk("t1_idle_valid", 32'(rd_valid), 32'd0);

        // T2: write burst on id0
        set_req(0, 16'h0100, 6'd3);
        req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            req = 3'b000;
            wr_data = wd[i];
            #1;
            chk("t2_we", 32'(mem_we), 32'd1);
            chk("t2_re", 32'(mem_re), 32'd0);
            chk("t2_addr", 32'(mem_addr), 32'h100 + 32'(i));
            chk("t2_wdata", 32'(mem_wdata), 32'(wd[i]));
            chk("t2_beat_ack", 32'(beat_ack), 32'h1);
        end
        step();
        chk("t2_done", 32'(burst_done), 32'h1);
        chk("t2_gap_we", 32'(mem_we), 32'd0);
        chk("t2_gap_wdata", 32'(mem_wdata), 32'd0);
        step();

        // T3: id0 priority and reader round robin (rr now prefers id2 after T1)
        set_req(0, 16'h0200, 6'd2);
        set_req(1, 16'h0300, 6'd2);
        set_req(2, 16'h0400, 6'd2);
        req = 3'b111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, n);
            chk("t3_order", 32'(g), 32'(exp_g[k]));
            chk("t3_onehot_ack", 32'($onehot(beat_ack)), 32'd1);
            if (k > 0) chk("t3_turnaround", 32'(n), 32'd1);
            case (k)
                0: req = 3'b110;
                2: req = 3'b111;
                3: req = 3'b110;
                4: req = 3'b000;
                default: ;
            endcase
            wait_clear();
        end
        step();

        // T4: address wrap on id2
        set_req(2, 16'hFFFE, 6'd4);
        req = 3'b100;
        ea = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            step();
            req = 3'b000;
            chk("t4_addr", 32'(mem_addr), 32'(ea));
            chk("t4_ack", 32'(beat_ack), 32'h4);
            ea = ea + 16'd1;
        end
        step();
        chk("t4_done", 32'(burst_done), 32'h4);
        step();

        // T5: zero-length read goes straight to the turnaround cycle
        set_req(1, 16'h0050, 6'd0);
        req = 3'b010;
        step();
        req = 3'b000;
        chk("t5_gnt", 32'(gnt), 32'h2);
        chk("t5_done", 32'(burst_done), 32'h2);
        chk("t5_no_re", 32'(mem_re), 32'd0);
        chk("t5_no_ack", 32'(beat_ack), 32'd0);
        step();
        chk("t5_idle_gnt", 32'(gnt), 32'd0);
        chk("t5_idle_done", 32'(burst_done), 32'd0);
        chk("t5_no_valid", 32'(rd_valid), 32'd0);

        // T6: asynchronous reset in the middle of a long read
        set_req(1, 16'h0600, 6'd8);
        req = 3'b010;
        step(); step(); step();
        req = 3'b000;
        chk("t6_beat2_addr", 32'(mem_addr), 32'h602);
        #2 rst = 1'b1;
        #1;
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_ack", 32'(beat_ack), 32'd0);
        chk("t6_re", 32'(mem_re), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_valid", 32'(rd_valid), 32'd0);
        chk("t6_rd_data", 32'(rd_data), 32'd0);
        step();
        chk("t6_no_done", 32'(burst_done), 32'd0);
        rst = 1'b0;
        set_req(1, 16'h0700, 6'd1);
        set_req(2, 16'h0800, 6'd1);
        req = 3'b110;
        step();
        req = 3'b000;
        chk("t6_regrant", 32'(gnt), 32'h2);
        chk("t6_regrant_addr", 32'(mem_addr), 32'h700);
        step();
        chk("t6_regrant_done", 32'(burst_done), 32'h2);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
